tm1638_if: RTL and testbench
============================

Name: tm1638_if

Overview:
- Byte-level serial master for a TM1638 LED/key driver chip: clock and data lines only. Chip select (STB) is owned by the surrounding controller.
- A host strobes `data_latch` to do one transfer:
  - write: shifts an 8-bit byte out on `dio_out`, LSB first, clocked by `sclk`;
  - read: shifts 8 bits in from `dio_in`, LSB first, and presents them on the bidirectional `data` bus.
- Sits between a command sequencer and the chip pins (`dio_out`/`dio_in` merged by an external tri-state buffer).

Parameters:
- CLK_DIV, default 4: `sclk` half-period in `clk` cycles (`sclk` period = 2*CLK_DIV clocks; minimum 1).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_latch`  in  1  one-cycle start strobe; sampled only when idle.
- `data`  inout  8  write byte (driven by host when `rw`=1); read result (driven by block when `rw`=0).
- `rw`  in  1  1 = write to chip, 0 = read from chip; sampled with `data_latch`.
- `busy`  out  1  high for the whole transfer.
- `sclk`  out  1  serial clock to chip; idles high.
- `dio_out`  out  1  serial data to chip; idles high.
- `dio_in`  in  1  serial data from chip.

Behaviour:
- Reset (async, any time including mid-transfer):
  - `busy`=0, `sclk`=1, `dio_out`=1;
  - read register=0x00, bit counter=0, divider=0;
  - state = IDLE.
- `data` bus drive: `data` = read register when `rw`=0, else high-Z. This is combinational on `rw`, independent of `busy`.
- States: IDLE, LOW, HIGH.
- IDLE:
  - On a clock edge with `data_latch`=1:
    - capture `rw` into `dir`;
    - if `rw`=1, capture `data` into the shift register;
    - `busy`<=1, `sclk`<=0, bit index=0, divider=0;
    - `dio_out` <= `data`[0] for a write, 1 for a read;
    - go to LOW.
- LOW:
  - `sclk`=0 for CLK_DIV clocks.
  - Then `sclk`<=1, go to HIGH.
  - On that same edge, if `dir`=read, `rxreg`[bit] <= `dio_in`. Sampling happens at the `sclk` rising transition.
- HIGH:
  - `sclk`=1 for CLK_DIV clocks.
  - Then, if bit<7:
    - bit<=bit+1, `sclk`<=0;
    - `dio_out` <= next tx bit (write) or 1 (read);
    - go to LOW.
  - If bit=7:
    - `busy`<=0, `dio_out`<=1, `sclk` stays 1;
    - go to IDLE.
- Data changes only while `sclk` is low and is stable across each rising edge, as the TM1638 requires.
- Timing:
  - `busy` asserts the edge after the latch is sampled and stays high exactly 16*CLK_DIV clocks (64 by default).
  - Back-to-back latch is accepted on the first edge after `busy` falls.
- Boundary conditions:
  - `data_latch` while `busy` is ignored (no restart, no queueing).
  - `rw` and `data` changes during a transfer have no effect on it. The `data` drive direction still follows live `rw`.
  - The read register retains its value until the next completed bit sample of a read. It is overwritten bit-by-bit during a read.
  - A write transfer leaves the read register unchanged.

Decomposition:
- Shared package tm1638_pkg:
  - state enum (IDLE, LOW, HIGH);
  - constant BITS_PER_BYTE=8;
  - default CLK_DIV.
- One natural sub-module: tm1638_clkdiv. It is a half-period counter producing a one-cycle `tick` every CLK_DIV clocks when enabled, and clears on disable or reset.
- The shift/FSM logic stays in tm1638_if.

Test Plan:
- Reset: assert `rst` mid-operation and async (between clock edges) -> `busy`=0, `sclk`=1, `dio_out`=1 immediately; later reads of `data` with `rw`=0 give 0x00.
- Write 0x40 (`rw`=1, one-cycle `data_latch`):
  - 8 `sclk` low pulses of 4 clocks each;
  - `dio_out` at each rising edge = 0,0,0,0,0,0,1,0;
  - `busy` high 64 clocks;
  - `dio_out`=1 and `sclk`=1 after.
- Write 0xAA then 0x55 back-to-back (≥100 clocks apart) -> bit sequences 0,1,0,1,0,1,0,1 and 1,0,1,0,1,0,1,0; `busy` drops between transfers.
- Read with `dio_in` presenting bits 1,0,1,0,1,0,1,0 (changing every 8 clocks, stable at each `sclk` rise):
  - `dio_out` held 1 throughout;
  - after `busy` falls, `data`=0x55 while `rw`=0.
- Read with pattern 0,1,0,1,0,1,0,1 -> `data`=0xAA. Also set `rw`=1 -> `data` released to high-Z.
- Pulse `data_latch` with `rw` toggled while `busy` -> transfer unaffected, no second transfer starts, `busy` still exactly 64 clocks.

Source files
------------

// File: rtl/tm1638_pkg.sv
// tm1638_pkg: shared definitions for the TM1638 byte-level serial master.
//   state_t          - transfer state machine encoding (IDLE, LOW, HIGH)
//   BITS_PER_BYTE    - bits shifted per transfer
//   DEFAULT_CLK_DIV  - default sclk half-period in clk cycles
package tm1638_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2
   } state_t;

   localparam int BITS_PER_BYTE   = 8;
   localparam int DEFAULT_CLK_DIV = 4;

endpackage

// File: rtl/tm1638_if_if.sv
// tm1638_if_if: host handshake and chip-pin bundle for tm1638_if.
//   data_latch  host -> block   one-cycle start strobe
//   rw          host -> block   1 = write to chip, 0 = read from chip
//   busy        block -> host   high for the whole transfer
//   sclk        block -> chip   serial clock, idles high
//   dio_out     block -> chip   serial data out, idles high
//   dio_in      chip -> block   serial data in
// The 8-bit bidirectional data bus stays a plain inout port on the block.
// "master" is the environment side (host sequencer plus chip pins),
// "slave" is the serial master block itself.
interface tm1638_if_if;

   logic data_latch;
   logic rw;
   logic busy;
   logic sclk;
   logic dio_out;
   logic dio_in;

   modport master (
      output data_latch, rw, dio_in,
      input  busy, sclk, dio_out
   );

   modport slave (
      input  data_latch, rw, dio_in,
      output busy, sclk, dio_out
   );

endinterface

// File: rtl/tm1638_clkdiv.sv
// tm1638_clkdiv: half-period counter for the serial clock.
//   clk, rst  system clock, async active-high reset
//   en        count while high; counter clears while low
//   tick      one-cycle pulse on every CLK_DIV-th enabled clock
module tm1638_clkdiv #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Tick on the last count of the half period; wrap so the next half starts at zero.
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (!en) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
         tick  = 1'b1;
      end else begin
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tm1638_if.sv
// tm1638_if: byte-level serial master for a TM1638 (sclk + dio only; STB is
// handled outside). A data_latch strobe in idle starts one 8-bit transfer,
// LSB first: write shifts the captured byte out on dio_out, read samples
// dio_in on each sclk rising edge into the read register.
//   clk, rst  system clock, async active-high reset
//   bus       tm1638_if_if.slave (data_latch, rw, busy, sclk, dio_out, dio_in)
//   data      8-bit inout: host drives it when rw=1, block drives the read
//             register onto it when rw=0
module tm1638_if
   import tm1638_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic           clk,
   input  logic           rst,
   tm1638_if_if.slave     bus,
   inout  wire  [7:0]     data
);

   localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

   state_t     state_q, state_d;
   logic       dir_q, dir_d;        // 1 = write, 0 = read
   logic [7:0] shreg_q, shreg_d;    // tx byte, shifted right as bits go out
   logic [7:0] rx_q, rx_d;
   logic [2:0] bit_q, bit_d;
   logic       busy_q, busy_d;
   logic       sclk_q, sclk_d;
   logic       dout_q, dout_d;
   logic       tick_s;

   tm1638_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q != ST_IDLE),
      .tick (tick_s)
   );

   // Drive direction follows live rw, independent of any transfer in flight.
   assign data = bus.rw ? 8'hzz : rx_q;

   assign bus.busy    = busy_q;
   assign bus.sclk    = sclk_q;
   assign bus.dio_out = dout_q;

   // Transfer state machine: dio_out only moves on the edge that drops sclk,
   // and dio_in is captured on the edge that raises it.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      shreg_d = shreg_q;
      rx_d    = rx_q;
      bit_d   = bit_q;
      busy_d  = busy_q;
      sclk_d  = sclk_q;
      dout_d  = dout_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.data_latch) begin
               dir_d   = bus.rw;
               if (bus.rw) begin
                  shreg_d = data;
               end else begin
                  shreg_d = shreg_q;
               end
               busy_d  = 1'b1;
               sclk_d  = 1'b0;
               bit_d   = 3'd0;
               dout_d  = bus.rw ? data[0] : 1'b1;
               state_d = ST_LOW;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOW: begin
            if (tick_s) begin
               sclk_d  = 1'b1;
               state_d = ST_HIGH;
               if (!dir_q) begin
                  rx_d[bit_q] = bus.dio_in;
               end else begin
                  rx_d = rx_q;
               end
            end else begin
               state_d = ST_LOW;
            end
         end
         ST_HIGH: begin
            if (tick_s) begin
               if (bit_q != LAST_BIT) begin
                  bit_d   = bit_q + 3'd1;
                  sclk_d  = 1'b0;
                  // shreg_q[1] is the next bit to send before the shift lands.
                  shreg_d = {1'b1, shreg_q[7:1]};
                  dout_d  = dir_q ? shreg_q[1] : 1'b1;
                  state_d = ST_LOW;
               end else begin
                  busy_d  = 1'b0;
                  dout_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_HIGH;
            end
         end
         default: begin
            busy_d  = 1'b0;
            sclk_d  = 1'b1;
            dout_d  = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dir_q   <= 1'b0;
         shreg_q <= 8'h00;
         rx_q    <= 8'h00;
         bit_q   <= 3'd0;
         busy_q  <= 1'b0;
         sclk_q  <= 1'b1;
         dout_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         shreg_q <= shreg_d;
         rx_q    <= rx_d;
         bit_q   <= bit_d;
         busy_q  <= busy_d;
         sclk_q  <= sclk_d;
         dout_q  <= dout_d;
      end
   end

endmodule

// File: tb/tb_tm1638_if.sv
// tb_tm1638_if: directed self-checking bench for tm1638_if (CLK_DIV = 4).
module tb_tm1638_if;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] drv;
   wire  [7:0] data;

   int n_chk = 0;
   int n_bad = 0;

   tm1638_if_if bus ();

   assign data = bus.rw ? drv : 8'hzz;

   tm1638_if #(.CLK_DIV(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .data (data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One transfer: strobe latch, then watch pins on each falling clk edge.
   // seen[k] = dio_out at the k-th sclk rise; dio_in presents pat[k] while
   // sclk is low before the k-th rise.
   task automatic xfer(input logic w, input logic [7:0] b, input logic [7:0] pat,
                       input logic disturb, output logic [7:0] seen,
                       output int bcnt, output int rises, output int lows);
      logic prev;
      logic done;
      @(negedge clk);
      bus.rw = w;
      drv = b;
      bus.data_latch = 1'b1;
      seen = 8'h00;
      bcnt = 0;
      rises = 0;
      lows = 0;
      prev = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (i == 0) bus.data_latch = 1'b0;
         if (disturb && i == 20) begin
            bus.data_latch = 1'b1;
            bus.rw = ~w;
            drv = ~b;
         end
         if (disturb && i == 21) bus.data_latch = 1'b0;
         if (bus.busy) bcnt++;
         if (bus.busy && !bus.sclk) begin
            lows++;
            if (rises < 8) bus.dio_in = pat[rises[2:0]];
         end
         if (!prev && bus.sclk) begin
            if (rises < 8) seen[rises[2:0]] = bus.dio_out;
            rises++;
         end
         prev = bus.sclk;
         if (bcnt > 0 && !bus.busy) done = 1'b1;
      end
      bus.rw = w;
      drv = b;
      chk("xfer_done", {31'd0, done}, 32'd1);
      chk("end_sclk", {31'd0, bus.sclk}, 32'd1);
      chk("end_dout", {31'd0, bus.dio_out}, 32'd1);
      chk("busy_len", bcnt, 32'd64);
      chk("rises", rises, 32'd8);
      chk("low_clks", lows, 32'd32);
   endtask

   logic [7:0] seen;
   int bcnt, rises, lows, extra;

   initial begin
      rst = 1'b1;
      bus.data_latch = 1'b0;
      bus.rw = 1'b0;
      bus.dio_in = 1'b1;
      drv = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_sclk", {31'd0, bus.sclk}, 32'd1);
      chk("rst_dout", {31'd0, bus.dio_out}, 32'd1);
      chk("rst_data", {24'd0, data}, 32'h00);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Write 0x40: bits 0,0,0,0,0,0,1,0.
      xfer(1'b1, 8'h40, 8'hFF, 1'b0, seen, bcnt, rises, lows);
      chk("wr40_bits", {24'd0, seen}, 32'h40);

      // Write 0xAA then 0x55, with a gap; busy must drop in between.
      xfer(1'b1, 8'hAA, 8'hFF, 1'b0, seen, bcnt, rises, lows);
      chk("wrAA_bits", {24'd0, seen}, 32'hAA);
      repeat (40) @(negedge clk);
      chk("gap_busy", {31'd0, bus.busy}, 32'd0);
      xfer(1'b1, 8'h55, 8'hFF, 1'b0, seen, bcnt, rises, lows);
      chk("wr55_bits", {24'd0, seen}, 32'h55);

      // Read pattern 1,0,1,0,1,0,1,0 -> 0x55; dio_out must stay high.
      xfer(1'b0, 8'h00, 8'h55, 1'b0, seen, bcnt, rises, lows);
      chk("rd55_dout", {24'd0, seen}, 32'hFF);
      chk("rd55_data", {24'd0, data}, 32'h55);

      // Read pattern 0,1,0,1,... -> 0xAA, then release the bus with rw=1.
      xfer(1'b0, 8'h00, 8'hAA, 1'b0, seen, bcnt, rises, lows);
      chk("rdAA_dout", {24'd0, seen}, 32'hFF);
      chk("rdAA_data", {24'd0, data}, 32'hAA);
      bus.rw = 1'b1;
      drv = 8'h3C;
      #1;
      chk("release", {24'd0, data}, 32'h3C);

      // Write 0x96 with latch, rw and data disturbed mid-transfer.
      xfer(1'b1, 8'h96, 8'hFF, 1'b1, seen, bcnt, rises, lows);
      chk("dist_bits", {24'd0, seen}, 32'h96);
      extra = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.busy) extra++;
      end
      chk("no_restart", extra, 32'd0);
      bus.rw = 1'b0;
      #1;
      chk("rx_kept", {24'd0, data}, 32'hAA);

      // Async reset in the middle of a transfer, between clock edges.
      @(negedge clk);
      bus.rw = 1'b1;
      drv = 8'h00;
      bus.data_latch = 1'b1;
      @(negedge clk);
      bus.data_latch = 1'b0;
      repeat (20) @(negedge clk);
      chk("mid_busy", {31'd0, bus.busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", {31'd0, bus.busy}, 32'd0);
      chk("arst_sclk", {31'd0, bus.sclk}, 32'd1);
      chk("arst_dout", {31'd0, bus.dio_out}, 32'd1);
      bus.rw = 1'b0;
      #1;
      chk("arst_data", {24'd0, data}, 32'h00);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_busy", {31'd0, bus.busy}, 32'd0);
      chk("post_data", {24'd0, data}, 32'h00);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
